// File: rtl/axi_stream_trace_decoder_if.sv
// Bundles the tagged trace stream input and the decoded record output of the trace decoder.
// Both channels use valid/ready: a transfer happens on a rising clk edge where valid & ready are both 1,
// and the source holds valid and its payload stable until that edge.
interface axi_stream_trace_decoder_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 32,
  parameter int DEST_WIDTH = 32,
  parameter int USER_WIDTH = 64
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] s_tdata;
  logic [STRB_W-1:0]     s_tstrb;
  logic [STRB_W-1:0]     s_tkeep;
  logic [ID_WIDTH-1:0]   s_tid;
  logic [DEST_WIDTH-1:0] s_tdest;
  logic [USER_WIDTH-1:0] s_tuser;
  logic                  s_tlast;
  logic                  s_tvalid;
  logic                  s_tready;

  logic                  rec_valid;
  logic                  rec_ready;
  logic [2:0]            rec_type;
  logic [ADDR_WIDTH-1:0] rec_addr;
  logic [DATA_WIDTH-1:0] rec_data;
  logic [STRB_W-1:0]     rec_strb;
  logic [1:0]            rec_resp;

  modport master (
    output s_tdata, s_tstrb, s_tkeep, s_tid, s_tdest, s_tuser, s_tlast, s_tvalid,
    input  s_tready,
    input  rec_valid, rec_type, rec_addr, rec_data, rec_strb, rec_resp,
    output rec_ready
  );

  modport slave (
    input  s_tdata, s_tstrb, s_tkeep, s_tid, s_tdest, s_tuser, s_tlast, s_tvalid,
    output s_tready,
    output rec_valid, rec_type, rec_addr, rec_data, rec_strb, rec_resp,
    input  rec_ready
  );
endinterface

// File: rtl/axi_stream_trace_decoder.sv
// Decodes the tagged AXI4 snoop trace stream back into one record per AR/AW/B beat or R/W header+data pair,
// with saturating per-type and protocol-error counters.
module axi_stream_trace_decoder #(
  parameter int DATA_WIDTH        = 128,
  parameter int ADDR_WIDTH        = 64,
  parameter int STREAM_TYPE_WIDTH = 3,
  parameter int ID_WIDTH          = 32,
  parameter int DEST_WIDTH        = 32,
  parameter int USER_WIDTH        = 64,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  axi_stream_trace_decoder_if.slave bus,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] cnt_ar,
  output logic [CNT_WIDTH-1:0] cnt_aw,
  output logic [CNT_WIDTH-1:0] cnt_r,
  output logic [CNT_WIDTH-1:0] cnt_w,
  output logic [CNT_WIDTH-1:0] cnt_b,
  output logic [CNT_WIDTH-1:0] cnt_err,
  output logic [1:0]           dbg_state
);
  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [STREAM_TYPE_WIDTH-1:0] TAG_AR = STREAM_TYPE_WIDTH'(0);
  localparam logic [STREAM_TYPE_WIDTH-1:0] TAG_R  = STREAM_TYPE_WIDTH'(1);
  localparam logic [STREAM_TYPE_WIDTH-1:0] TAG_AW = STREAM_TYPE_WIDTH'(2);
  localparam logic [STREAM_TYPE_WIDTH-1:0] TAG_W  = STREAM_TYPE_WIDTH'(3);
  localparam logic [STREAM_TYPE_WIDTH-1:0] TAG_B  = STREAM_TYPE_WIDTH'(4);

  localparam logic [2:0] REC_AR = 3'd0;
  localparam logic [2:0] REC_R  = 3'd1;
  localparam logic [2:0] REC_AW = 3'd2;
  localparam logic [2:0] REC_W  = 3'd3;
  localparam logic [2:0] REC_B  = 3'd4;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t state, state_nx;

  logic                  rec_valid_q;
  logic [2:0]            rec_type_q;
  logic [ADDR_WIDTH-1:0] rec_addr_q;
  logic [DATA_WIDTH-1:0] rec_data_q;
  logic [STRB_W-1:0]     rec_strb_q;
  logic [1:0]            rec_resp_q;

  logic                  hdr_w, hdr_w_nx;
  logic [STRB_W-1:0]     hdr_strb, hdr_strb_nx;

  logic                  ld;
  logic [2:0]            ld_type;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [STRB_W-1:0]     ld_strb;
  logic [1:0]            ld_resp;
  logic                  err;

  logic                         accept;
  logic [STREAM_TYPE_WIDTH-1:0] tag;
  logic                         unused_inputs;

  assign unused_inputs = ^{bus.s_tstrb, bus.s_tkeep, bus.s_tid, bus.s_tdest, bus.s_tuser};

  // DROP always drains; otherwise a beat is taken only when the single record slot can accept a load.
  assign bus.s_tready = resetn & ((state == S_DROP) | ~rec_valid_q | bus.rec_ready);
  assign accept       = bus.s_tvalid & bus.s_tready;
  assign tag          = bus.s_tdata[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH];

  assign bus.rec_valid = rec_valid_q;
  assign bus.rec_type  = rec_type_q;
  assign bus.rec_addr  = rec_addr_q;
  assign bus.rec_data  = rec_data_q;
  assign bus.rec_strb  = rec_strb_q;
  assign bus.rec_resp  = rec_resp_q;
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_HDR;
      hdr_w    <= 1'b0;
      hdr_strb <= '0;
    end else begin
      state    <= state_nx;
      hdr_w    <= hdr_w_nx;
      hdr_strb <= hdr_strb_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    hdr_w_nx    = hdr_w;
    hdr_strb_nx = hdr_strb;
    ld          = 1'b0;
    ld_type     = REC_AR;
    ld_addr     = '0;
    ld_data     = '0;
    ld_strb     = '0;
    ld_resp     = '0;
    err         = 1'b0;
    if (accept) begin
      unique case (state)
        S_HDR: begin
          case (tag)
            TAG_AR, TAG_AW: begin
              if (bus.s_tlast) begin
                ld      = 1'b1;
                ld_type = (tag == TAG_AR) ? REC_AR : REC_AW;
                ld_addr = bus.s_tdata[ADDR_WIDTH-1:0];
              end else begin
                err      = 1'b1;
                state_nx = S_DROP;
              end
            end
            TAG_B: begin
              if (bus.s_tlast) begin
                ld      = 1'b1;
                ld_type = REC_B;
                ld_resp = bus.s_tdata[1:0];
              end else begin
                err      = 1'b1;
                state_nx = S_DROP;
              end
            end
            TAG_R, TAG_W: begin
              // A one-beat R/W header has no payload to pair with; it is discarded.
              if (bus.s_tlast) begin
                err = 1'b1;
              end else begin
                state_nx = S_DATA;
                hdr_w_nx = (tag == TAG_W);
                if (tag == TAG_W) hdr_strb_nx = bus.s_tdata[STRB_W-1:0];
              end
            end
            default: begin
              err = 1'b1;
              if (!bus.s_tlast) state_nx = S_DROP;
            end
          endcase
        end
        S_DATA: begin
          if (bus.s_tlast) begin
            ld       = 1'b1;
            ld_type  = hdr_w ? REC_W : REC_R;
            ld_data  = bus.s_tdata;
            ld_strb  = hdr_w ? hdr_strb : '1;
            state_nx = S_HDR;
          end else begin
            err      = 1'b1;
            state_nx = S_DROP;
          end
        end
        default: begin
          if (bus.s_tlast) state_nx = S_HDR;
        end
      endcase
    end
  end

  // A load in the same cycle as rec_ready replaces the retiring record, keeping rec_valid high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rec_valid_q <= 1'b0;
      rec_type_q  <= '0;
      rec_addr_q  <= '0;
      rec_data_q  <= '0;
      rec_strb_q  <= '0;
      rec_resp_q  <= '0;
    end else if (ld) begin
      rec_valid_q <= 1'b1;
      rec_type_q  <= ld_type;
      rec_addr_q  <= ld_addr;
      rec_data_q  <= ld_data;
      rec_strb_q  <= ld_strb;
      rec_resp_q  <= ld_resp;
    end else if (bus.rec_ready) begin
      rec_valid_q <= 1'b0;
    end
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn || cnt_clear) begin
      cnt_ar  <= '0;
      cnt_aw  <= '0;
      cnt_r   <= '0;
      cnt_w   <= '0;
      cnt_b   <= '0;
      cnt_err <= '0;
    end else begin
      if (ld && ld_type == REC_AR) cnt_ar <= sat_inc(cnt_ar);
      if (ld && ld_type == REC_AW) cnt_aw <= sat_inc(cnt_aw);
      if (ld && ld_type == REC_R)  cnt_r  <= sat_inc(cnt_r);
      if (ld && ld_type == REC_W)  cnt_w  <= sat_inc(cnt_w);
      if (ld && ld_type == REC_B)  cnt_b  <= sat_inc(cnt_b);
      if (err)                     cnt_err <= sat_inc(cnt_err);
    end
  end
endmodule

// File: tb/tb_axi_stream_trace_decoder.sv
// Directed bench for axi_stream_trace_decoder: record decode, backpressure, drops, counters and reset.
module tb_axi_stream_trace_decoder;
  localparam int CW    = 4;
  localparam int REC_W = 3 + 64 + 128 + 16 + 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic cnt_clear = 1'b0;
  logic [CW-1:0] cnt_ar, cnt_aw, cnt_r, cnt_w, cnt_b, cnt_err;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] got_q[$];

  axi_stream_trace_decoder_if #(.DATA_WIDTH(128), .ADDR_WIDTH(64)) bus ();

  axi_stream_trace_decoder #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .cnt_clear(cnt_clear),
    .cnt_ar(cnt_ar), .cnt_aw(cnt_aw), .cnt_r(cnt_r), .cnt_w(cnt_w), .cnt_b(cnt_b),
    .cnt_err(cnt_err), .dbg_state(dbg_state)
  );

  // clock / reset-independent housekeeping
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] mk(input logic [2:0] t, input logic [124:0] low);
    return {t, low};
  endfunction

  function automatic logic [REC_W-1:0] pack_rec(input logic [2:0] t, input logic [63:0] a,
                                                input logic [127:0] d, input logic [15:0] s,
                                                input logic [1:0] r);
    return {t, a, d, s, r};
  endfunction

  // monitor: every retired record goes to got_q
  always @(posedge clk) begin
    if (resetn && bus.rec_valid && bus.rec_ready)
      got_q.push_back(pack_rec(bus.rec_type, bus.rec_addr, bus.rec_data, bus.rec_strb, bus.rec_resp));
  end

  // driver: present one beat, return #1 after the edge that accepted it
  task automatic send_beat(input logic [127:0] d, input logic last);
    int n = 0;
    bit done = 0;
    bus.s_tdata  = d;
    bus.s_tlast  = last;
    bus.s_tvalid = 1'b1;
    #1;
    while (!done) begin
      if (bus.s_tready === 1'b1) done = 1;
      @(posedge clk); #1;
      if (!done) begin
        n++;
        if (n > 50) begin
          n_cmp++; n_err++;
          $display("FAIL beat_accept_timeout: got no s_tready within 50 cycles, required acceptance");
          done = 1;
        end
      end
    end
    bus.s_tvalid = 1'b0;
  endtask

  task automatic retire();
    bus.rec_ready = 1'b1;
    @(posedge clk); #1;
    bus.rec_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.s_tdata = mk(3'd0, 125'h1); bus.s_tlast = 1'b1; bus.s_tvalid = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (bus.s_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b want 0", bus.s_tready); end
    n_cmp++; if (bus.rec_valid !== 1'b0) begin n_err++; $display("FAIL reset_rec_valid: got %b want 0", bus.rec_valid); end
    n_cmp++; if ({bus.rec_type, bus.rec_addr, bus.rec_data, bus.rec_strb, bus.rec_resp} !== '0) begin
      n_err++; $display("FAIL reset_rec_fields: got nonzero want 0"); end
    n_cmp++; if ({cnt_ar, cnt_aw, cnt_r, cnt_w, cnt_b, cnt_err} !== '0) begin
      n_err++; $display("FAIL reset_counters: got %h want 0", {cnt_ar, cnt_aw, cnt_r, cnt_w, cnt_b, cnt_err}); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    bus.s_tvalid = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ar();
    bus.rec_ready = 1'b0;
    send_beat(mk(3'd0, 125'h1000), 1'b1);
    n_cmp++; if (bus.rec_valid !== 1'b1) begin n_err++; $display("FAIL ar_valid: got %b want 1", bus.rec_valid); end
    n_cmp++; if (bus.rec_type !== 3'd0) begin n_err++; $display("FAIL ar_type: got %0d want 0", bus.rec_type); end
    n_cmp++; if (bus.rec_addr !== 64'h1000) begin n_err++; $display("FAIL ar_addr: got %h want 1000", bus.rec_addr); end
    n_cmp++; if (cnt_ar !== 4'd1) begin n_err++; $display("FAIL ar_cnt: got %0d want 1", cnt_ar); end
    retire();
    n_cmp++; if (bus.rec_valid !== 1'b0) begin n_err++; $display("FAIL ar_retire: got %b want 0", bus.rec_valid); end
  endtask

  task automatic test_w();
    bus.rec_ready = 1'b0;
    send_beat(mk(3'd3, 125'h00FF), 1'b0);
    n_cmp++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL w_hdr_state: got %0d want 1", dbg_state); end
    n_cmp++; if (bus.rec_valid !== 1'b0) begin n_err++; $display("FAIL w_hdr_novalid: got %b want 0", bus.rec_valid); end
    send_beat(128'hDEAD_BEEF, 1'b1);
    n_cmp++; if (bus.rec_type !== 3'd3) begin n_err++; $display("FAIL w_type: got %0d want 3", bus.rec_type); end
    n_cmp++; if (bus.rec_data !== 128'hDEAD_BEEF) begin n_err++; $display("FAIL w_data: got %h want DEADBEEF", bus.rec_data); end
    n_cmp++; if (bus.rec_strb !== 16'h00FF) begin n_err++; $display("FAIL w_strb: got %h want 00ff", bus.rec_strb); end
    n_cmp++; if (bus.rec_addr !== 64'h0) begin n_err++; $display("FAIL w_addr: got %h want 0", bus.rec_addr); end
    n_cmp++; if (cnt_w !== 4'd1) begin n_err++; $display("FAIL w_cnt: got %0d want 1", cnt_w); end
    retire();
  endtask

  task automatic test_r_stall();
    bus.rec_ready = 1'b0;
    send_beat(mk(3'd1, 125'h0), 1'b0);
    send_beat(128'h1234, 1'b1);
    bus.s_tdata = mk(3'd2, 125'h2000); bus.s_tlast = 1'b1; bus.s_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.s_tready !== 1'b0) begin n_err++; $display("FAIL r_stall_tready: got %b want 0", bus.s_tready); end
      n_cmp++; if ({bus.rec_valid, bus.rec_type, bus.rec_data, bus.rec_strb} !== {1'b1, 3'd1, 128'h1234, 16'hFFFF}) begin
        n_err++; $display("FAIL r_stall_hold: got type %0d data %h strb %h want 1 1234 ffff",
                          bus.rec_type, bus.rec_data, bus.rec_strb); end
    end
    bus.rec_ready = 1'b1; #1;
    n_cmp++; if (bus.s_tready !== 1'b1) begin n_err++; $display("FAIL r_release_tready: got %b want 1", bus.s_tready); end
    @(posedge clk); #1;
    bus.s_tvalid = 1'b0; bus.rec_ready = 1'b0;
    n_cmp++; if ({bus.rec_valid, bus.rec_type, bus.rec_addr} !== {1'b1, 3'd2, 64'h2000}) begin
      n_err++; $display("FAIL r_then_aw: got v%b type %0d addr %h want 1 2 2000", bus.rec_valid, bus.rec_type, bus.rec_addr); end
    n_cmp++; if ({cnt_r, cnt_aw} !== {4'd1, 4'd1}) begin
      n_err++; $display("FAIL r_aw_cnt: got r %0d aw %0d want 1 1", cnt_r, cnt_aw); end
    retire();
  endtask

  task automatic test_back_to_back();
    logic [127:0] beats[4];
    beats[0] = mk(3'd2, 125'h3000); beats[1] = mk(3'd4, 125'h2);
    beats[2] = mk(3'd2, 125'h4000); beats[3] = mk(3'd4, 125'h1);
    got_q.delete(); exp_q.delete();
    exp_q.push_back(pack_rec(3'd2, 64'h3000, '0, '0, 2'd0));
    exp_q.push_back(pack_rec(3'd4, 64'h0, '0, '0, 2'd2));
    exp_q.push_back(pack_rec(3'd2, 64'h4000, '0, '0, 2'd0));
    exp_q.push_back(pack_rec(3'd4, 64'h0, '0, '0, 2'd1));
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s_tdata = beats[i]; bus.s_tlast = 1'b1; bus.s_tvalid = 1'b1; #1;
      n_cmp++; if (bus.s_tready !== 1'b1) begin n_err++; $display("FAIL b2b_stall[%0d]: got tready %b want 1", i, bus.s_tready); end
      @(posedge clk); #1;
      if (i == 1) begin
        n_cmp++; if ({bus.rec_type, bus.rec_resp} !== {3'd4, 2'd2}) begin
          n_err++; $display("FAIL b2b_b_resp: got type %0d resp %0d want 4 2", bus.rec_type, bus.rec_resp); end
      end
    end
    bus.s_tvalid = 1'b0;
    @(posedge clk); #1;
    bus.rec_ready = 1'b0;
    n_cmp++; if (got_q.size() !== 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [REC_W-1:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL b2b_record: got %h want %h", g, e); end
    end
    n_cmp++; if ({cnt_aw, cnt_b} !== {4'd3, 4'd2}) begin
      n_err++; $display("FAIL b2b_cnt: got aw %0d b %0d want 3 2", cnt_aw, cnt_b); end
  endtask

  task automatic test_drop();
    bus.rec_ready = 1'b1;
    got_q.delete();
    send_beat(mk(3'd6, 125'h0), 1'b0);
    n_cmp++; if (dbg_state !== 2'd2) begin n_err++; $display("FAIL drop_state: got %0d want 2", dbg_state); end
    send_beat(mk(3'd0, 125'hAAAA), 1'b0);
    send_beat(mk(3'd0, 125'hBBBB), 1'b1);
    @(posedge clk); #1;
    n_cmp++; if (cnt_err !== 4'd1) begin n_err++; $display("FAIL drop_err: got %0d want 1", cnt_err); end
    n_cmp++; if (got_q.size() !== 0 || bus.rec_valid !== 1'b0) begin
      n_err++; $display("FAIL drop_norecord: got %0d records valid %b want 0 0", got_q.size(), bus.rec_valid); end
    send_beat(mk(3'd0, 125'h5000), 1'b1);
    n_cmp++; if ({bus.rec_valid, bus.rec_type, bus.rec_addr} !== {1'b1, 3'd0, 64'h5000}) begin
      n_err++; $display("FAIL drop_next_ar: got v%b type %0d addr %h want 1 0 5000", bus.rec_valid, bus.rec_type, bus.rec_addr); end
    n_cmp++; if (cnt_ar !== 4'd2) begin n_err++; $display("FAIL drop_ar_cnt: got %0d want 2", cnt_ar); end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    bus.rec_ready = 1'b1;
    got_q.delete();
    send_beat(mk(3'd1, 125'h0), 1'b1);
    n_cmp++; if ({dbg_state, cnt_err} !== {2'd0, 4'd2}) begin
      n_err++; $display("FAIL err_r_single: got state %0d err %0d want 0 2", dbg_state, cnt_err); end
    send_beat(mk(3'd0, 125'h99), 1'b0);
    n_cmp++; if ({dbg_state, cnt_err} !== {2'd2, 4'd3}) begin
      n_err++; $display("FAIL err_ar_nolast: got state %0d err %0d want 2 3", dbg_state, cnt_err); end
    send_beat(mk(3'd0, 125'h99), 1'b1);
    send_beat(mk(3'd3, 125'hF), 1'b0);
    send_beat(128'h55, 1'b0);
    n_cmp++; if ({dbg_state, cnt_err} !== {2'd2, 4'd4}) begin
      n_err++; $display("FAIL err_data_nolast: got state %0d err %0d want 2 4", dbg_state, cnt_err); end
    send_beat(mk(3'd4, 125'h0), 1'b1);
    @(posedge clk); #1;
    n_cmp++; if ({dbg_state, cnt_w, 8'(got_q.size())} !== {2'd0, 4'd1, 8'd0}) begin
      n_err++; $display("FAIL err_norecords: got state %0d w %0d recs %0d want 0 1 0", dbg_state, cnt_w, got_q.size()); end
  endtask

  task automatic test_saturation();
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 15; i++) send_beat(mk(3'd4, 125'h0), 1'b1);
    n_cmp++; if (cnt_b !== 4'hF) begin n_err++; $display("FAIL sat_b: got %0d want 15", cnt_b); end
    n_cmp++; if (cnt_ar !== 4'd2) begin n_err++; $display("FAIL sat_ar_untouched: got %0d want 2", cnt_ar); end
    cnt_clear = 1'b1;
    send_beat(mk(3'd4, 125'h0), 1'b1);
    cnt_clear = 1'b0;
    n_cmp++; if ({cnt_ar, cnt_aw, cnt_r, cnt_w, cnt_b, cnt_err} !== '0) begin
      n_err++; $display("FAIL sat_clear: got %h want 0", {cnt_ar, cnt_aw, cnt_r, cnt_w, cnt_b, cnt_err}); end
    send_beat(mk(3'd4, 125'h0), 1'b1);
    n_cmp++; if (cnt_b !== 4'd1) begin n_err++; $display("FAIL sat_after_clear: got %0d want 1", cnt_b); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bus.rec_ready = 1'b0;
    send_beat(mk(3'd4, 125'h1), 1'b1);
    resetn = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({bus.rec_valid, bus.rec_type, bus.rec_resp, cnt_b} !== '0) begin
      n_err++; $display("FAIL rst_pending: got v%b type %0d resp %0d b %0d want 0", bus.rec_valid, bus.rec_type, bus.rec_resp, cnt_b); end
    resetn = 1'b1;
    bus.rec_ready = 1'b1;
    send_beat(mk(3'd3, 125'hF0F0), 1'b0);
    n_cmp++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL rst_hdr_state: got %0d want 1", dbg_state); end
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_mid_state: got %0d want 0", dbg_state); end
    send_beat(mk(3'd0, 125'h77), 1'b1);
    n_cmp++; if ({bus.rec_type, bus.rec_addr, bus.rec_strb} !== {3'd0, 64'h77, 16'h0}) begin
      n_err++; $display("FAIL rst_restart: got type %0d addr %h strb %h want 0 77 0", bus.rec_type, bus.rec_addr, bus.rec_strb); end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.s_tdata = '0; bus.s_tstrb = '0; bus.s_tkeep = '0; bus.s_tid = '0;
    bus.s_tdest = '0; bus.s_tuser = '0; bus.s_tlast = 1'b0; bus.s_tvalid = 1'b0;
    bus.rec_ready = 1'b0;
    test_reset();
    test_ar();
    test_w();
    test_r_stall();
    test_back_to_back();
    test_drop();
    test_errors();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
